// File: rtl/azpr_uart_rx.sv
// ---------------------------------------------------------------------------
// azpr_uart_rx
//   UART receiver. Frame format: 8 data bits, no parity, 1 stop bit, LSB
//   first. The line idles high. Each bit is sampled once, at its midpoint.
//   When a frame ends with a valid stop bit, the byte appears on rx_data and
//   rx_end pulses for one cycle. This block also serves as a loopback or
//   bench monitor on a uart_tx line.
//
// Parameters
//   DIV_RATE : clock cycles per bit. Must be >= 4.
//   DIV_W    : width of the baud divider counter. Must hold DIV_RATE-1.
//
// Ports
//   clk     : system clock. All logic runs on its rising edge.
//   reset   : asynchronous reset, active low.
//   rx      : serial input. Asynchronous to clk. Idles at 1.
//   rx_busy : high while a frame is being received.
//   rx_end  : one-cycle strobe. The frame ended with a valid stop bit.
//   rx_data : last valid received byte. Updated only together with rx_end.
// ---------------------------------------------------------------------------
module azpr_uart_rx #(
    parameter int DIV_RATE = 260,
    parameter int DIV_W    = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rx_busy,
    output logic       rx_end,
    output logic [7:0] rx_data
);

    // The first wait covers half a bit, so the start bit is sampled at its
    // middle. Every later wait covers a full bit.
    localparam logic [DIV_W-1:0] HALF_CNT = DIV_W'(DIV_RATE / 2 - 1);
    localparam logic [DIV_W-1:0] FULL_CNT = DIV_W'(DIV_RATE - 1);
    localparam logic [3:0]       STOP_BIT = 4'd9;

    typedef enum logic {
        IDLE,
        RX
    } state_t;

    state_t           state;
    logic             sync1;
    logic             rx_s;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       bit_cnt;
    logic [7:0]       shift;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            rx_busy <= 1'b0;
            rx_end  <= 1'b0;
            rx_data <= 8'h00;
        end else begin
            // Two-stage synchroniser. Every decision below uses rx_s only.
            sync1  <= rx;
            rx_s   <= sync1;
            rx_end <= 1'b0;

            case (state)
                IDLE: begin
                    // The FSM checks for a start bit on every IDLE cycle.
                    // Back-to-back frames therefore need no idle gap. A line
                    // still held low after a framing error is also taken as
                    // a new start bit.
                    if (!rx_s) begin
                        state   <= RX;
                        rx_busy <= 1'b1;
                        bit_cnt <= '0;
                        div_cnt <= HALF_CNT;
                    end
                end

                RX: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else if (bit_cnt == 4'd0) begin
                        if (rx_s) begin
                            // The line went back high before the middle of
                            // the start bit. This is a glitch, so drop it.
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            bit_cnt <= 4'd1;
                            div_cnt <= FULL_CNT;
                        end
                    end else if (bit_cnt == STOP_BIT) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                        bit_cnt <= '0;
                        // A stop bit of 0 is a framing error. The byte is
                        // dropped and rx_data keeps its previous value.
                        if (rx_s) begin
                            rx_data <= shift;
                            rx_end  <= 1'b1;
                        end
                    end else begin
                        // Data bits arrive LSB first. Each new bit enters at
                        // the top, so bit 0 reaches shift[0] after eight bits.
                        shift   <= {rx_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        div_cnt <= FULL_CNT;
                    end
                end

                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_azpr_uart_rx.sv
module tb_azpr_uart_rx;

    localparam int DIV_RATE = 16;
    localparam int DIV_W    = 9;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       rx_busy;
    logic       rx_end;
    logic [7:0] rx_data;

    int         total;
    int         bad;
    int         end_count;
    logic       prev_end;
    logic [7:0] exp_q[$];

    azpr_uart_rx #(
        .DIV_RATE(DIV_RATE),
        .DIV_W   (DIV_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rx     (rx),
        .rx_busy(rx_busy),
        .rx_end (rx_end),
        .rx_data(rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock. Sample the outputs 1 time unit after the edge, then
    // drive the next rx value. When rx_end is seen, the oldest expected byte
    // is popped from the scoreboard and compared.
    task automatic step_cycle(input logic v);
        logic [7:0] e;
        @(posedge clk);
        #1;
        if (rx_end) begin
            end_count++;
            total++;
            if (prev_end) begin
                bad++;
                $display("FAIL rx_end_width: rx_end=1 in two consecutive cycles, required a single-cycle pulse");
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rx_end: rx_data=%02h, required no rx_end", rx_data);
            end else begin
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    bad++;
                    $display("FAIL rx_data: got %02h, required %02h", rx_data, e);
                end
            end
            total++;
            if (rx_busy !== 1'b0) begin
                bad++;
                $display("FAIL busy_at_end: rx_busy=%b, required 0 in the rx_end cycle", rx_busy);
            end
            $display("rx_end: rx_data=%02h", rx_data);
        end
        prev_end = rx_end;
        rx = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step_cycle(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        if (stop) exp_q.push_back(d);
        $display("send frame %02h stop=%b", d, stop);
        for (int b = 0; b < 10; b++)
            for (int c = 0; c < DIV_RATE; c++) step_cycle(bits[b]);
    endtask

    task automatic test_reset;
        int ec0;
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", rx_busy); end
        total++;
        if (rx_end !== 1'b0) begin bad++; $display("FAIL reset_end: got %b, required 0", rx_end); end
        total++;
        if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %02h, required 00", rx_data); end
        reset = 1'b1;
        ec0 = end_count;
        idle(100);
        total++;
        if (end_count !== ec0) begin bad++; $display("FAIL idle_no_end: rx_end count %0d, required %0d", end_count, ec0); end
        $display("test_reset done");
    endtask

    task automatic test_frame_55;
        int ec0;
        ec0 = end_count;
        send_frame(8'h55, 1'b1);
        idle(30);
        total++;
        if (end_count !== ec0 + 1) begin bad++; $display("FAIL frame55_count: got %0d, required %0d", end_count, ec0 + 1); end
        total++;
        if (rx_data !== 8'h55) begin bad++; $display("FAIL frame55_hold: rx_data=%02h, required 55", rx_data); end
    endtask

    task automatic test_back_to_back;
        int ec0;
        ec0 = end_count;
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        idle(30);
        total++;
        if (end_count !== ec0 + 2) begin bad++; $display("FAIL b2b_count: got %0d, required %0d", end_count, ec0 + 2); end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_pending: %0d bytes outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_glitch;
        int ec0;
        ec0 = end_count;
        $display("glitch: 3-cycle low pulse");
        step_cycle(1'b0);
        step_cycle(1'b0);
        total++;
        if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_e1: got %b, required 0", rx_busy); end
        step_cycle(1'b0);
        total++;
        if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_e2: got %b, required 0", rx_busy); end
        step_cycle(1'b1);
        total++;
        if (rx_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_e3: got %b, required 1", rx_busy); end
        idle(30);
        total++;
        if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_after: got %b, required 0", rx_busy); end
        total++;
        if (end_count !== ec0) begin bad++; $display("FAIL glitch_no_end: count %0d, required %0d", end_count, ec0); end
        total++;
        if (rx_data !== 8'h0F) begin bad++; $display("FAIL glitch_data: got %02h, required 0F", rx_data); end
    endtask

    task automatic test_framing_error;
        int ec0;
        ec0 = end_count;
        send_frame(8'h7E, 1'b0);
        idle(40);
        total++;
        if (end_count !== ec0) begin bad++; $display("FAIL frame_err_end: count %0d, required %0d", end_count, ec0); end
        total++;
        if (rx_data !== 8'h0F) begin bad++; $display("FAIL frame_err_data: got %02h, required 0F", rx_data); end
        send_frame(8'h42, 1'b1);
        idle(30);
        total++;
        if (end_count !== ec0 + 1) begin bad++; $display("FAIL after_err_count: got %0d, required %0d", end_count, ec0 + 1); end
        total++;
        if (rx_data !== 8'h42) begin bad++; $display("FAIL after_err_data: got %02h, required 42", rx_data); end
    endtask

    task automatic test_reset_mid_frame;
        logic [8:0] bits;
        int ec0;
        bits = {8'h5A, 1'b0};
        $display("partial frame 5A, reset during data bit 4");
        // Start bit plus data bits 0..3 in full, then half of data bit 4.
        for (int b = 0; b < 5; b++)
            for (int c = 0; c < DIV_RATE; c++) step_cycle(bits[b]);
        for (int c = 0; c < DIV_RATE / 2; c++) step_cycle(bits[5]);
        total++;
        if (rx_busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b, required 1", rx_busy); end
        #2 reset = 1'b0;
        #1;
        total++;
        if (rx_busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy: got %b, required 0", rx_busy); end
        total++;
        if (rx_end !== 1'b0) begin bad++; $display("FAIL mid_reset_end: got %b, required 0", rx_end); end
        total++;
        if (rx_data !== 8'h00) begin bad++; $display("FAIL mid_reset_data: got %02h, required 00", rx_data); end
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        ec0 = end_count;
        idle(30);
        send_frame(8'h99, 1'b1);
        idle(30);
        total++;
        if (end_count !== ec0 + 1) begin bad++; $display("FAIL post_reset_count: got %0d, required %0d", end_count, ec0 + 1); end
        total++;
        if (rx_data !== 8'h99) begin bad++; $display("FAIL post_reset_data: got %02h, required 99", rx_data); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        end_count = 0;
        prev_end  = 1'b0;
        reset     = 1'b0;
        rx        = 1'b1;
        test_reset();
        test_frame_55();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_reset_mid_frame();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d bytes outstanding, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
